// File: rtl/acl_spi_responder.sv
// SPI-mode-0 slave emulating an accelerometer register interface (command, address, data
// with auto-increment) on top of a local byte register file that the fabric can also load.
module acl_spi_responder #(
  parameter int         NUM_REGS  = 64,
  parameter logic [7:0] DEVID     = 8'hAD,
  parameter logic [7:0] CMD_WRITE = 8'h0A,
  parameter logic [7:0] CMD_READ  = 8'h0B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       csn_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic       loc_we_i,
  input  logic [7:0] loc_addr_i,
  input  logic [7:0] loc_wdata_i,
  output logic [7:0] loc_rdata_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t     state_q;
  logic [2:0] sclk_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] addr_q;
  logic [7:0] tx_q;
  logic       is_rd_q;
  logic       miso_q;
  logic       wr_valid_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [NUM_REGS];

  logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic       byte_done, spi_we;
  logic [7:0] rx_byte_d;

  function automatic logic wr_ok(input logic [7:0] a);
    return (a != 8'h00) && ({1'b0, a} < 9'(NUM_REGS));
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] a);
    if (a == 8'h00)
      return DEVID;
    else if ({1'b0, a} < 9'(NUM_REGS))
      return regs_q[a[AW-1:0]];
    else
      return 8'h00;
  endfunction

  // Two-flop synchronizers plus a third stage used only for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000;
      csn_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      csn_q  <= {csn_q[1:0], csn_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign csn_rise  = csn_q[1] & ~csn_q[2];
  assign csn_fall  = ~csn_q[1] & csn_q[2];
  assign rx_byte_d = {rx_q, mosi_q[1]};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign spi_we    = (state_q == S_WDATA) && byte_done && !csn_rise && wr_ok(addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 7'd0;
      addr_q     <= 8'h00;
      tx_q       <= 8'h00;
      is_rd_q    <= 1'b0;
      miso_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      wr_valid_q <= 1'b0;
      if (csn_rise) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
      end else begin
        if (sclk_rise && state_q != S_IDLE) begin
          rx_q      <= rx_byte_d[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        case (state_q)
          S_IDLE: begin
            if (csn_fall) begin
              state_q   <= S_CMD;
              bit_cnt_q <= 3'd0;
            end
          end
          S_CMD: begin
            if (byte_done) begin
              if (rx_byte_d == CMD_WRITE) begin
                is_rd_q <= 1'b0;
                state_q <= S_ADDR;
              end else if (rx_byte_d == CMD_READ) begin
                is_rd_q <= 1'b1;
                state_q <= S_ADDR;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_ADDR: begin
            if (byte_done) begin
              addr_q <= rx_byte_d;
              if (is_rd_q) begin
                tx_q    <= reg_read(rx_byte_d);
                state_q <= S_RDATA;
              end else begin
                state_q <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (byte_done) begin
              if (wr_ok(addr_q)) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= rx_byte_d;
              end
              addr_q <= addr_q + 8'd1;
            end
          end
          S_RDATA: begin
            // The next byte is snapshotted here, so later local writes cannot disturb it.
            if (byte_done) begin
              addr_q <= addr_q + 8'd1;
              tx_q   <= reg_read(addr_q + 8'd1);
            end else if (sclk_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          S_IGNORE: miso_q <= 1'b0;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Register file: the SPI write is applied last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      if (loc_we_i && wr_ok(loc_addr_i))
        regs_q[loc_addr_i[AW-1:0]] <= loc_wdata_i;
      if (spi_we)
        regs_q[addr_q[AW-1:0]] <= rx_byte_d;
    end
  end

  assign loc_rdata_o = reg_read(loc_addr_i);
  assign miso_o      = miso_q;
  assign miso_oe_o   = ~csn_q[1];
  assign busy_o      = ~csn_q[1];
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Randomized bench for acl_spi_responder: a byte-level register model predicts MISO bytes,
// write pulses and the register image; directed cases pin the model with literal values.
module tb_acl_spi_responder;

  localparam int NUM_REGS = 64;

  logic       clk = 1'b0;
  logic       rst, sclk, csn, mosi;
  logic       miso, miso_oe, loc_we, wr_valid, busy;
  logic [7:0] loc_addr, loc_wdata, loc_rdata, wr_addr, wr_data;

  acl_spi_responder #(.NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .loc_we_i(loc_we), .loc_addr_i(loc_addr),
    .loc_wdata_i(loc_wdata), .loc_rdata_o(loc_rdata), .wr_valid_o(wr_valid),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register image plus expected write-pulse queue.
  logic [7:0]  mem [256];
  logic [15:0] exp_wr [$];

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    if (a == 8'h00) return 8'hAD;
    if (int'(a) < NUM_REGS) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic writable(input logic [7:0] a);
    return (a != 8'h00) && (int'(a) < NUM_REGS);
  endfunction

  // Transaction description.
  logic [7:0] tx_b [16];
  logic [7:0] rx_b [16];
  logic [7:0] exp_rx [16];
  int n_full, tail_bits, abort_bit;
  bit coll_en;
  int coll_byte;
  logic [7:0] coll_a, coll_d;

  task automatic predict();
    logic [7:0] a;
    for (int k = 0; k < 16; k++) exp_rx[k] = 8'h00;
    if (n_full < 2) return;
    a = tx_b[1];
    for (int k = 2; k < n_full; k++) begin
      if (tx_b[0] == 8'h0B) begin
        exp_rx[k] = model_rd(a);
      end else if (tx_b[0] == 8'h0A) begin
        if (writable(a)) begin
          mem[a] = tx_b[k];
          exp_wr.push_back({a, tx_b[k]});
        end
        if (coll_en && k == coll_byte && coll_a != a && writable(coll_a))
          mem[coll_a] = coll_d;
      end
      a = a + 8'd1;
    end
  endtask

  task automatic run_spi();
    int total, bb, bi;
    total = n_full * 8 + tail_bits;
    for (int k = 0; k < 16; k++) rx_b[k] = 8'h00;
    @(negedge clk);
    csn = 1'b0;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      bb = i / 8;
      bi = 7 - (i % 8);
      if (i == abort_bit) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        break;
      end
      sclk = 1'b0;
      mosi = tx_b[bb][bi];
      repeat (4) @(negedge clk);
      rx_b[bb][bi] = miso;
      sclk = 1'b1;
      if (coll_en && bb == coll_byte && bi == 0) begin
        repeat (2) @(negedge clk);
        loc_we = 1'b1;
        loc_addr = coll_a;
        loc_wdata = coll_d;
        @(negedge clk);
        loc_we = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (6) @(negedge clk);
    chk("miso_idle", miso, 0);
  endtask

  task automatic xfer();
    predict();
    run_spi();
    for (int k = 0; k < n_full; k++) chk($sformatf("miso_byte%0d", k), rx_b[k], exp_rx[k]);
    chk("wr_pulses_missing", exp_wr.size(), 0);
    exp_wr.delete();
    coll_en = 1'b0;
    abort_bit = -1;
    tail_bits = 0;
  endtask

  task automatic loc_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_we = 1'b1;
    loc_addr = a;
    loc_wdata = d;
    @(negedge clk);
    loc_we = 1'b0;
    if (writable(a)) mem[a] = d;
  endtask

  task automatic get_reg(input logic [7:0] a, output logic [7:0] d);
    loc_addr = a;
    #1;
    d = loc_rdata;
  endtask

  task automatic scan();
    logic [7:0] d;
    for (int a = 0; a < 256; a++) begin
      get_reg(8'(a), d);
      chk($sformatf("reg%02h", a), d, model_rd(8'(a)));
    end
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(8'hF0, 8'hFF));
    return 8'($urandom_range(0, NUM_REGS + 7));
  endfunction

  // Per-cycle checker: busy/oe once csn has settled, and every write pulse.
  int stable = 0;
  logic csn_prev = 1'b1;
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      stable = 0;
    end else begin
      if (csn == csn_prev) stable++;
      else stable = 0;
      csn_prev = csn;
      if (stable >= 3) begin
        chk("busy", busy, !csn);
        chk("miso_oe", miso_oe, !csn);
      end
      if (wr_valid) begin
        if (exp_wr.size() == 0) begin
          chk("wr_extra_pulse", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", wr_addr, e[15:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, c;
    int kind;
    rst = 1'b1; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
    loc_we = 1'b0; loc_addr = 8'h00; loc_wdata = 8'h00;
    n_full = 0; tail_bits = 0; abort_bit = -1; coll_en = 1'b0; coll_byte = 0;
    coll_a = 8'h00; coll_d = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_miso", miso, 0);
    chk("reset_oe", miso_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_valid", wr_valid, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    scan();

    // DEVID read
    tx_b[0] = 8'h0B; tx_b[1] = 8'h00; tx_b[2] = 8'h5A; n_full = 3;
    xfer();
    chk("lit_devid", rx_b[2], 8'hAD);
    chk("lit_busy_after", busy, 0);
    chk("lit_oe_after", miso_oe, 0);

    // Write burst
    tx_b[0] = 8'h0A; tx_b[1] = 8'h20; tx_b[2] = 8'h55; tx_b[3] = 8'h66; n_full = 4;
    xfer();
    get_reg(8'h20, d); chk("lit_reg20", d, 8'h55);
    get_reg(8'h21, d); chk("lit_reg21", d, 8'h66);

    // Read across the end of the register file
    loc_write(8'h3F, 8'h12);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h3F; n_full = 5;
    xfer();
    chk("lit_rd3f", rx_b[2], 8'h12);
    chk("lit_rd40", rx_b[3], 8'h00);
    chk("lit_rd41", rx_b[4], 8'h00);

    // Partial data byte is discarded
    tx_b[0] = 8'h0A; tx_b[1] = 8'h10; tx_b[2] = 8'hFF; n_full = 2; tail_bits = 5;
    xfer();
    get_reg(8'h10, d); chk("lit_reg10_partial", d, 8'h00);

    // Unknown command, then normal decode
    tx_b[0] = 8'h33; tx_b[1] = 8'hFF; tx_b[2] = 8'hFF; n_full = 3;
    xfer();
    tx_b[0] = 8'h0B; tx_b[1] = 8'h00; n_full = 3;
    xfer();
    chk("lit_devid_after_ignore", rx_b[2], 8'hAD);

    // Collisions: same address (SPI wins), different address (both land)
    tx_b[0] = 8'h0A; tx_b[1] = 8'h05; tx_b[2] = 8'h77; n_full = 3;
    coll_en = 1'b1; coll_byte = 2; coll_a = 8'h05; coll_d = 8'hAA;
    xfer();
    get_reg(8'h05, d); chk("lit_coll_same", d, 8'h77);
    tx_b[0] = 8'h0A; tx_b[1] = 8'h07; tx_b[2] = 8'h11; n_full = 3;
    coll_en = 1'b1; coll_byte = 2; coll_a = 8'h06; coll_d = 8'hAA;
    xfer();
    get_reg(8'h06, d); chk("lit_coll_diff_loc", d, 8'hAA);
    get_reg(8'h07, d); chk("lit_coll_diff_spi", d, 8'h11);
    loc_write(8'h00, 8'h99);
    scan();

    // Randomized transactions
    for (int t = 0; t < 48; t++) begin
      kind = $urandom_range(0, 9);
      for (int k = 0; k < 16; k++) tx_b[k] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) loc_write(rand_addr(), 8'($urandom));
      if (kind <= 3 || kind <= 7) begin
        tx_b[0] = (kind <= 3) ? 8'h0A : 8'h0B;
        tx_b[1] = rand_addr();
        n_full = 2 + $urandom_range(0, 3);
        tail_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        xfer();
      end else if (kind == 8) begin
        c = 8'($urandom);
        while (c == 8'h0A || c == 8'h0B) c = 8'($urandom);
        tx_b[0] = c;
        n_full = $urandom_range(1, 3);
        xfer();
      end else begin
        for (int k = 0; k < 3; k++) loc_write(rand_addr(), 8'($urandom));
      end
      if (t % 12 == 11) scan();
    end
    scan();

    // Reset in the middle of a write burst
    tx_b[0] = 8'h0A; tx_b[1] = 8'h30; tx_b[2] = 8'h99; tx_b[3] = 8'h44;
    n_full = 3; tail_bits = 4; abort_bit = 26;
    xfer();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_wr_addr", wr_addr, 0);
    chk("post_rst_wr_data", wr_data, 0);
    get_reg(8'h30, d); chk("lit_reg30_cleared", d, 8'h00);
    get_reg(8'h00, d); chk("lit_reg0_after_rst", d, 8'hAD);
    scan();
    tx_b[0] = 8'h0B; tx_b[1] = 8'h00; n_full = 3;
    xfer();
    chk("lit_devid_after_rst", rx_b[2], 8'hAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
